// File: rtl/sat_acc_pkg.sv
// Shared types and constants for the saturating block accumulator.
// Provides the two-state FSM type and the signed saturation bounds.
package sat_acc_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Largest positive W-bit two's complement value: 0111..1
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Most negative W-bit two's complement value: 1000..0
    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/sat_add_param.sv
// Combinational W-bit signed saturating adder.
// Ports: a, b (W-bit signed operands); sum (W-bit clamped result);
//        ovf (1 when the wrapped sum left the representable range).
module sat_add_param
    import sat_acc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    localparam logic [W-1:0] MAXV = W'(sat_max(W));
    localparam logic [W-1:0] MINV = W'(sat_min(W));

    logic [W-1:0] raw;

    assign raw = a + b;

    // Overflow only possible when both operands share a sign and the
    // wrapped result flipped it.
    assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

    always_comb begin
        sum = raw;
        if (ovf) begin
            sum = a[W-1] ? MINV : MAXV;
        end
    end

endmodule

// File: rtl/saturating_accumulator.sv
// Sums each block of N signed W-bit samples with saturating addition and
// presents one result per block over a valid/ready handshake.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data (sample
//        stream); out_valid/out_ready/out_data/out_sat (block result and
//        sticky saturation flag).
// Option: define SAT_ACC_OVF_COUNT_EN to add ovf_cnt, the number of
//         saturating adds in the current block.
module saturating_accumulator
    import sat_acc_pkg::*;
#(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic                     out_sat
`ifdef SAT_ACC_OVF_COUNT_EN
    ,
    output logic [$clog2(N+1)-1:0]   ovf_cnt
`endif
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic          sat;

    logic [W-1:0]  sum;
    logic          ovf;
    logic          take;
    logic          give;

    sat_add_param #(
        .W(W)
    ) u_add (
        .a  (acc),
        .b  (in_data),
        .sum(sum),
        .ovf(ovf)
    );

    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);
    assign take      = in_valid & in_ready;
    assign give      = out_valid & out_ready;

    // Result ports read as zero outside HOLD so nothing partial leaks out.
    assign out_data  = out_valid ? acc : '0;
    assign out_sat   = out_valid & sat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            unique case (state)
                ACC: begin
                    if (take) begin
                        acc <= sum;
                        sat <= sat | ovf;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= HOLD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= ACC;
                        acc   <= '0;
                        sat   <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef SAT_ACC_OVF_COUNT_EN
    localparam int OW = $clog2(N + 1);

    logic [OW-1:0] ocnt;

    // Accepts never happen in HOLD, so the count is naturally held there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ocnt <= '0;
        end else if (give) begin
            ocnt <= '0;
        end else if (take && ovf) begin
            ocnt <= ocnt + OW'(1);
        end
    end

    assign ovf_cnt = ocnt;
`endif

endmodule
